// File: rtl/genius_controle_param.sv
// Simon-style memory game controller with runtime game length and optional player-extended
// sequence; drives an external asynchronous-read sequence RAM.
module genius_controle_param #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned N_LEDS    = 4,
    parameter int unsigned T_MOSTRA  = 1000,
    parameter int unsigned T_APAGA   = 500,
    parameter int unsigned T_TIMEOUT = 5000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] limite,
    input  logic              modo_escrita,
    input  logic              jogada,
    input  logic [N_LEDS-1:0] botoes,
    input  logic [N_LEDS-1:0] mem_dado,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic              mem_escreve,
    output logic [N_LEDS-1:0] mem_dado_escrito,
    output logic [N_LEDS-1:0] leds,
    output logic              acertou,
    output logic              errou,
    output logic              timeout,
    output logic              pronto,
    output logic [4:0]        db_estado,
    output logic [ADDR_W-1:0] db_sequencia,
    output logic [ADDR_W-1:0] db_endereco
);

    localparam int unsigned TMAX_A = (T_MOSTRA > T_APAGA) ? T_MOSTRA : T_APAGA;
    localparam int unsigned TMAX   = (TMAX_A > T_TIMEOUT) ? TMAX_A : T_TIMEOUT;
    localparam int unsigned TW     = $clog2(TMAX + 1);

    localparam logic [TW-1:0] FIM_MOSTRA  = TW'(T_MOSTRA - 1);
    localparam logic [TW-1:0] FIM_APAGA   = TW'(T_APAGA - 1);
    localparam logic [TW-1:0] FIM_TIMEOUT = TW'(T_TIMEOUT - 1);

    localparam logic [4:0] ST_INICIAL       = 5'd0;
    localparam logic [4:0] ST_PREPARA       = 5'd1;
    localparam logic [4:0] ST_CARREGA       = 5'd2;
    localparam logic [4:0] ST_MOSTRA        = 5'd3;
    localparam logic [4:0] ST_APAGA         = 5'd4;
    localparam logic [4:0] ST_INTERVALO     = 5'd5;
    localparam logic [4:0] ST_PROX_POS      = 5'd6;
    localparam logic [4:0] ST_INICIO_JOGADA = 5'd7;
    localparam logic [4:0] ST_ESPERA        = 5'd8;
    localparam logic [4:0] ST_REGISTRA      = 5'd9;
    localparam logic [4:0] ST_COMPARA       = 5'd10;
    localparam logic [4:0] ST_PROX_JOGADA   = 5'd11;
    localparam logic [4:0] ST_FIM_RODADA    = 5'd12;
    localparam logic [4:0] ST_ESPERA_NOVA   = 5'd13;
    localparam logic [4:0] ST_ESCREVE_NOVA  = 5'd14;
    localparam logic [4:0] ST_PROX_RODADA   = 5'd15;
    localparam logic [4:0] ST_ACERTO        = 5'd16;
    localparam logic [4:0] ST_ERRO          = 5'd17;
    localparam logic [4:0] ST_TIMEOUT       = 5'd18;

    logic [4:0]        estado_q, estado_d;
    logic [ADDR_W-1:0] seq_q, seq_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [ADDR_W-1:0] lim_q, lim_d;
    logic              modo_q, modo_d;
    logic [N_LEDS-1:0] led_q, led_d;
    logic [N_LEDS-1:0] reg_q, reg_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [TW-1:0]     tmo_q, tmo_d;

    always_comb begin
        estado_d = estado_q;
        seq_d    = seq_q;
        end_d    = end_q;
        lim_d    = lim_q;
        modo_d   = modo_q;
        led_d    = led_q;
        reg_d    = reg_q;
        tmr_d    = tmr_q;
        tmo_d    = tmo_q;
        case (estado_q)
            ST_INICIAL: if (iniciar) estado_d = ST_PREPARA;
            ST_PREPARA: begin
                seq_d    = '0;
                end_d    = '0;
                lim_d    = limite;
                modo_d   = modo_escrita;
                estado_d = ST_CARREGA;
            end
            ST_CARREGA: begin
                led_d    = mem_dado;
                tmr_d    = '0;
                estado_d = ST_MOSTRA;
            end
            ST_MOSTRA: begin
                if (tmr_q == FIM_MOSTRA) estado_d = ST_APAGA;
                else                     tmr_d    = tmr_q + 1'b1;
            end
            ST_APAGA: begin
                led_d    = '0;
                tmr_d    = '0;
                estado_d = ST_INTERVALO;
            end
            ST_INTERVALO: begin
                if (tmr_q == FIM_APAGA) begin
                    estado_d = (end_q == seq_q) ? ST_INICIO_JOGADA : ST_PROX_POS;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_PROX_POS: begin
                end_d    = end_q + 1'b1;
                estado_d = ST_CARREGA;
            end
            ST_INICIO_JOGADA: begin
                end_d    = '0;
                tmo_d    = '0;
                estado_d = ST_ESPERA;
            end
            // A press on the final cycle wins over expiry
            ST_ESPERA: begin
                if (jogada)                    estado_d = ST_REGISTRA;
                else if (tmo_q == FIM_TIMEOUT) estado_d = ST_TIMEOUT;
                else                           tmo_d    = tmo_q + 1'b1;
            end
            ST_REGISTRA: begin
                reg_d    = botoes;
                estado_d = ST_COMPARA;
            end
            ST_COMPARA: begin
                if (reg_q != mem_dado)   estado_d = ST_ERRO;
                else if (end_q == seq_q) estado_d = ST_FIM_RODADA;
                else                     estado_d = ST_PROX_JOGADA;
            end
            ST_PROX_JOGADA: begin
                end_d    = end_q + 1'b1;
                tmo_d    = '0;
                estado_d = ST_ESPERA;
            end
            // Exiting before the increment keeps S from wrapping at full length
            ST_FIM_RODADA: begin
                if (seq_q == lim_q) begin
                    estado_d = ST_ACERTO;
                end else if (modo_q) begin
                    tmo_d    = '0;
                    estado_d = ST_ESPERA_NOVA;
                end else begin
                    estado_d = ST_PROX_RODADA;
                end
            end
            ST_ESPERA_NOVA: begin
                if (jogada) begin
                    reg_d    = botoes;
                    estado_d = ST_ESCREVE_NOVA;
                end else if (tmo_q == FIM_TIMEOUT) begin
                    estado_d = ST_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_ESCREVE_NOVA: estado_d = ST_PROX_RODADA;
            ST_PROX_RODADA: begin
                seq_d    = seq_q + 1'b1;
                end_d    = '0;
                estado_d = ST_CARREGA;
            end
            ST_ACERTO, ST_ERRO, ST_TIMEOUT: if (iniciar) estado_d = ST_PREPARA;
            default: estado_d = ST_INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= ST_INICIAL;
            seq_q    <= '0;
            end_q    <= '0;
            lim_q    <= '0;
            modo_q   <= 1'b0;
            led_q    <= '0;
            reg_q    <= '0;
            tmr_q    <= '0;
            tmo_q    <= '0;
        end else begin
            estado_q <= estado_d;
            seq_q    <= seq_d;
            end_q    <= end_d;
            lim_q    <= lim_d;
            modo_q   <= modo_d;
            led_q    <= led_d;
            reg_q    <= reg_d;
            tmr_q    <= tmr_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        mem_escreve      = (estado_q == ST_ESCREVE_NOVA);
        mem_endereco     = mem_escreve ? (seq_q + 1'b1) : end_q;
        mem_dado_escrito = mem_escreve ? reg_q : '0;
        leds             = (estado_q == ST_MOSTRA) ? led_q : '0;
        acertou          = (estado_q == ST_ACERTO);
        errou            = (estado_q == ST_ERRO);
        timeout          = (estado_q == ST_TIMEOUT);
        pronto           = acertou || errou || timeout;
        db_estado        = estado_q;
        db_sequencia     = seq_q;
        db_endereco      = end_q;
    end

endmodule

// File: tb/tb_genius_controle_param.sv
// Directed bench for genius_controle_param: win, wrong play, timeout, write mode, restart, reset.
module tb_genius_controle_param;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned N_LEDS = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              iniciar = 1'b0;
    logic [ADDR_W-1:0] limite = '0;
    logic              modo_escrita = 1'b0;
    logic              jogada = 1'b0;
    logic [N_LEDS-1:0] botoes = '0;
    logic [N_LEDS-1:0] mem_dado;
    logic [ADDR_W-1:0] mem_endereco;
    logic              mem_escreve;
    logic [N_LEDS-1:0] mem_dado_escrito;
    logic [N_LEDS-1:0] leds;
    logic              acertou, errou, timeout, pronto;
    logic [4:0]        db_estado;
    logic [ADDR_W-1:0] db_sequencia, db_endereco;

    logic [N_LEDS-1:0] ram [0:15] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0,
                                      4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    int n_writes = 0;
    int n_total  = 0;
    int n_bad    = 0;

    genius_controle_param #(
        .ADDR_W   (ADDR_W),
        .N_LEDS   (N_LEDS),
        .T_MOSTRA (4),
        .T_APAGA  (2),
        .T_TIMEOUT(20)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .iniciar         (iniciar),
        .limite          (limite),
        .modo_escrita    (modo_escrita),
        .jogada          (jogada),
        .botoes          (botoes),
        .mem_dado        (mem_dado),
        .mem_endereco    (mem_endereco),
        .mem_escreve     (mem_escreve),
        .mem_dado_escrito(mem_dado_escrito),
        .leds            (leds),
        .acertou         (acertou),
        .errou           (errou),
        .timeout         (timeout),
        .pronto          (pronto),
        .db_estado       (db_estado),
        .db_sequencia    (db_sequencia),
        .db_endereco     (db_endereco)
    );

    always #5 clock = ~clock;

    assign mem_dado = ram[mem_endereco];

    always @(posedge clock) begin
        if (mem_escreve) begin
            ram[mem_endereco] <= mem_dado_escrito;
            n_writes <= n_writes + 1;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_state(input string tag, input int st);
        int n = 0;
        while (int'(db_estado) != st && n < 300) begin
            tick();
            n++;
        end
        check_eq(tag, int'(db_estado), st);
    endtask

    task automatic press(input string tag, input int st, input int val);
        wait_state(tag, st);
        jogada = 1'b1;
        botoes = N_LEDS'(val);
        tick();
        jogada = 1'b0;
    endtask

    task automatic start(input int lim, input logic modo);
        limite       = ADDR_W'(lim);
        modo_escrita = modo;
        iniciar      = 1'b1;
        tick();
        iniciar      = 1'b0;
    endtask

    task automatic check_play(input string tag, input int exp);
        wait_state(tag, 3);
        check_eq(tag, int'(leds), exp);
        wait_state(tag, 4);
    endtask

    initial begin
        int n;
        int w0;
        // Reset state
        tick();
        check_eq("rst_estado", int'(db_estado), 0);
        check_eq("rst_leds", int'(leds), 0);
        check_eq("rst_pronto", int'(pronto), 0);
        check_eq("rst_addr", int'(mem_endereco), 0);
        check_eq("rst_we", int'(mem_escreve), 0);
        check_eq("rst_wdata", int'(mem_dado_escrito), 0);
        reset = 1'b0;
        tick();
        check_eq("idle_hold", int'(db_estado), 0);

        // Full win, limite=3, modo=0; first step timing
        start(3, 1'b0);
        check_eq("win_prepara", int'(db_estado), 1);
        tick();
        check_eq("win_carrega", int'(db_estado), 2);
        tick();
        check_eq("win_led0", int'(leds), 1);
        n = 0;
        while (leds == 4'd1 && n < 50) begin tick(); n++; end
        check_eq("win_lit_cycles", n, 4);
        check_eq("win_apaga", int'(db_estado), 4);
        tick();
        n = 0;
        while (db_estado == 5'd5 && n < 50) begin tick(); n++; end
        check_eq("win_dark_cycles", n, 2);
        check_eq("win_inicio_jogada", int'(db_estado), 7);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < r + 1; i++) press("win_press", 8, 1 << i);
        end
        wait_state("win_acerto", 16);
        check_eq("win_acertou", int'(acertou), 1);
        check_eq("win_pronto", int'(pronto), 1);
        check_eq("win_errou", int'(errou), 0);
        check_eq("win_seq", int'(db_sequencia), 3);

        // Wrong play in round 1
        start(3, 1'b0);
        press("err_r0", 8, 1);
        check_play("err_play0", 1);
        check_play("err_play1", 2);
        press("err_r1a", 8, 1);
        press("err_r1b", 8, 4);
        wait_state("err_erro", 17);
        check_eq("err_errou", int'(errou), 1);
        check_eq("err_pronto", int'(pronto), 1);
        check_eq("err_acertou", int'(acertou), 0);
        check_eq("err_seq", int'(db_sequencia), 1);

        // Restart from ERRO as a one-play game in write mode: no write expected
        w0 = n_writes;
        start(0, 1'b1);
        check_eq("l0_prepara", int'(db_estado), 1);
        press("l0_press", 8, 1);
        wait_state("l0_acerto", 16);
        check_eq("l0_acertou", int'(acertou), 1);
        check_eq("l0_nowrite", n_writes - w0, 0);

        // Timeout after exactly 20 idle cycles
        start(3, 1'b0);
        wait_state("to_espera", 8);
        n = 0;
        while (db_estado == 5'd8 && n < 100) begin tick(); n++; end
        check_eq("to_cycles", n, 20);
        check_eq("to_estado", int'(db_estado), 18);
        check_eq("to_timeout", int'(timeout), 1);
        check_eq("to_pronto", int'(pronto), 1);

        // A press on the last waiting cycle still registers
        start(3, 1'b0);
        wait_state("tj_espera", 8);
        for (int i = 0; i < 19; i++) tick();
        check_eq("tj_still_wait", int'(db_estado), 8);
        jogada = 1'b1;
        botoes = 4'd1;
        tick();
        jogada = 1'b0;
        check_eq("tj_registra", int'(db_estado), 9);

        // Stray iniciar and jogada during playback are ignored; then async reset
        wait_state("ign_mostra", 3);
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check_eq("ign_iniciar", int'(db_estado), 3);
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        check_eq("ign_jogada", int'(db_estado), 3);
        check_eq("ign_leds", int'(leds), 1);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_estado", int'(db_estado), 0);
        check_eq("arst_leds", int'(leds), 0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("arst_idle", int'(db_estado), 0);

        // Write mode, limite=2
        w0 = n_writes;
        start(2, 1'b1);
        press("wr_r0", 8, 1);
        press("wr_new1", 13, 8);
        check_eq("wr_state", int'(db_estado), 14);
        check_eq("wr_we", int'(mem_escreve), 1);
        check_eq("wr_addr", int'(mem_endereco), 1);
        check_eq("wr_data", int'(mem_dado_escrito), 8);
        tick();
        check_eq("wr_we_pulse", int'(mem_escreve), 0);
        check_eq("wr_prox_rodada", int'(db_estado), 15);
        check_play("wr_play1_0", 1);
        check_play("wr_play1_1", 8);
        press("wr_r1a", 8, 1);
        press("wr_r1b", 8, 8);
        press("wr_new2", 13, 4);
        check_eq("wr2_addr", int'(mem_endereco), 2);
        press("wr_r2a", 8, 1);
        press("wr_r2b", 8, 8);
        press("wr_r2c", 8, 4);
        wait_state("wr_acerto", 16);
        check_eq("wr_acertou", int'(acertou), 1);
        check_eq("wr_count", n_writes - w0, 2);
        check_eq("wr_ram2", int'(ram[2]), 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
